multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Multi-cycle MIPS control unit: the sequencing successor to the single-cycle decoder. A Moore/Mealy FSM steps each instruction through fetch, decode, execute, memory and writeback, and drives the datapath control strobes. Memory accesses use a ready handshake with variable wait states and a parametrised timeout. The FSM also maintains a retired-instruction counter and a sticky fault status. It sits between the instruction register (which supplies opcode/funct) and the shared-memory multi-cycle datapath.

Parameters:
ALU_CTRL_W, 4, width of alu_control (encodings: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111)
WAIT_W, 8, width of the memory wait-cycle counter
MEM_TIMEOUT, 255, wait cycles with mem_ready low before fault; 0 disables timeout (must be < 2^WAIT_W)
CNT_W, 32, width of instr_count

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
opcode  in  6  IR[31:26], stable from DECODE onward
funct  in  6  IR[5:0]
mem_ready  in  1  memory completes current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
iord  out  1  0 = PC address, 1 = ALUOut address
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  load IR
reg_dst  out  1  1 = rd, 0 = rt
mem_to_reg  out  1  1 = MDR to register file
reg_write  out  1  register file write
alu_src_a  out  1  0 = PC, 1 = A register
alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_control  out  ALU_CTRL_W  ALU operation
instr_done  out  1  one-cycle pulse on the final cycle of an instruction
instr_count  out  CNT_W  retired instructions
fault  out  1  sticky; FSM halted
fault_code  out  2  00 none, 01 memory timeout, 10 illegal opcode
state  out  4  current state encoding (debug)

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst). rst overrides everything, including mid-wait: state=FETCH, wait counter=0, instr_count=0, fault=0, fault_code=00.
- Every control output is 0 unless the current state asserts it.
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000.
- States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, FAULT=15.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ADD, pc_source=00. ir_write and pc_write assert only in the cycle mem_ready=1; the FSM then moves to DECODE. Otherwise it stays in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, ADD. Next state by opcode:
  - LW/SW -> MEM_ADDR
  - R -> EXECUTE
  - BEQ -> BRANCH
  - J -> JUMP
  - ADDI -> ADDI_EX
  - other -> FETCH with instr_done=1 (NOP)
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. LW goes to MEM_READ, SW to MEM_WRITE.
- MEM_READ: mem_read=1, iord=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done. Next state FETCH.
- MEM_WRITE: mem_write=1, iord=1. Wait for mem_ready; on that cycle instr_done=1 and the FSM moves to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_control from funct (100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, other AND). Next state ALU_WB.
- ALU_WB: reg_dst=1, reg_write=1, instr_done. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_write_cond=1, pc_source=01, instr_done. Next state FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done. Next state FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, ADD. Next state ADDI_WB.
- ADDI_WB: reg_dst=0, reg_write=1, instr_done. Next state FETCH.
- Latency with zero wait states, FETCH to FETCH: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3, NOP 2. Each wait cycle adds 1.
- Wait counter:
  - Cleared on entry to FETCH, MEM_READ or MEM_WRITE.
  - Increments each cycle those states see mem_ready=0.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT while mem_ready=0, the FSM goes to FAULT with fault_code=01.
  - mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT wins: no fault.
- FAULT: all strobes 0, fault=1. The FSM stays in FAULT until rst.
- instr_count increments by 1 on each instr_done and wraps modulo 2^CNT_W.

Optional Feature:
MCU_ILLEGAL_TRAP_EN:
- Defined: an unrecognised opcode in DECODE goes to FAULT with fault_code=10, and instr_done is not pulsed.
- Undefined: an unrecognised opcode is a 2-cycle NOP as above, and fault_code=10 never occurs.

Test Plan:
- rst high 2 cycles mid-MEM_READ wait -> state=0, all strobes 0, instr_count=0, fault=0.
- mem_ready tied 1; sequence R(ADD), LW, SW, BEQ, J, ADDI -> instr_done after 4, 5, 4, 3, 3, 4 cycles; EXECUTE alu_control=0010; instr_count=6.
- LW with mem_ready low 3 cycles in MEM_READ -> MEM_READ held 4 cycles, iord=1, then MEM_WB with reg_write=1 and mem_to_reg=1.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT on the 5th cycle, fault_code=01, stays in FAULT until rst.
- Opcode 111111 -> without macro: NOP, instr_done in DECODE. With MCU_ILLEGAL_TRAP_EN: fault_code=10.
- CNT_W=4, 17 J instructions -> instr_count=1 (wrap).

Source files
------------

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : multicycle_control_unit                                    |
// | Description : Multi-cycle MIPS control FSM. Sequences each instruction   |
// |               through fetch/decode/execute/memory/writeback, drives the  |
// |               datapath strobes, handles memory wait states with a        |
// |               timeout, counts retired instructions and latches a sticky  |
// |               fault status.                                              |
// | Ports       : clk, rst           clock / synchronous active-high reset   |
// |               opcode, funct      instruction register fields             |
// |               mem_ready          memory finishes the access this cycle   |
// |               pc_write .. alu_control   datapath control strobes         |
// |               instr_done         pulse on the last cycle of instruction  |
// |               instr_count        retired-instruction counter (wraps)     |
// |               fault, fault_code  sticky halt status                      |
// |               state              current FSM state (debug)               |
// | Options     : MCU_ILLEGAL_TRAP_EN - unknown opcodes trap to FAULT        |
// |               (fault_code 10) instead of retiring as a NOP.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module multicycle_control_unit #(
    parameter int ALU_CTRL_W  = 4,
    parameter int WAIT_W      = 8,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  pc_write_cond,
    output logic [1:0]            pc_source,
    output logic                  iord,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  instr_done,
    output logic [CNT_W-1:0]      instr_count,
    output logic                  fault,
    output logic [1:0]            fault_code,
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_FAULT     = 4'd15
    } state_t;

    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_J    = 6'b000010;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;

    localparam logic [ALU_CTRL_W-1:0] c_ALU_AND = ALU_CTRL_W'(4'b0000);
    localparam logic [ALU_CTRL_W-1:0] c_ALU_OR  = ALU_CTRL_W'(4'b0001);
    localparam logic [ALU_CTRL_W-1:0] c_ALU_ADD = ALU_CTRL_W'(4'b0010);
    localparam logic [ALU_CTRL_W-1:0] c_ALU_SUB = ALU_CTRL_W'(4'b0110);
    localparam logic [ALU_CTRL_W-1:0] c_ALU_SLT = ALU_CTRL_W'(4'b0111);

    state_t             r_state;
    state_t             w_next;
    logic [WAIT_W-1:0]  r_wait;
    logic [CNT_W-1:0]   r_count;
    logic [1:0]         r_fault_code;
    logic [1:0]         w_fault_set;
    logic               w_wait_state;
    logic               w_timeout;

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                          (r_state == S_MEM_WRITE);

    // The fault fires on the cycle whose increment would make the counter
    // reach MEM_TIMEOUT; a ready in that same cycle still completes.
    generate
        if (MEM_TIMEOUT != 0) begin : g_timeout
            assign w_timeout = w_wait_state && !mem_ready &&
                               (r_wait == WAIT_W'(MEM_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_wait       <= '0;
            r_count      <= '0;
            r_fault_code <= 2'b00;
        end else begin
            r_state <= w_next;
            // Any state change is an entry, so the counter starts fresh in
            // every wait state; it only advances while a wait state stalls.
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (w_wait_state && !mem_ready) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
            if (instr_done) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_fault_set != 2'b00) begin
                r_fault_code <= w_fault_set;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_fault_set   = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_control   = c_ALU_AND;
        instr_done    = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_read    = 1'b1;
                alu_src_b   = 2'b01;
                alu_control = c_ALU_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_timeout) begin
                    w_next      = S_FAULT;
                    w_fault_set = 2'b01;
                end
            end
            S_DECODE: begin
                alu_src_b   = 2'b11;
                alu_control = c_ALU_ADD;
                case (opcode)
                    c_OP_LW, c_OP_SW: w_next = S_MEM_ADDR;
                    c_OP_R:           w_next = S_EXECUTE;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_J:           w_next = S_JUMP;
                    c_OP_ADDI:        w_next = S_ADDI_EX;
                    default: begin
`ifdef MCU_ILLEGAL_TRAP_EN
                        w_next      = S_FAULT;
                        w_fault_set = 2'b10;
`else
                        w_next     = S_FETCH;
                        instr_done = 1'b1;
`endif
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = c_ALU_ADD;
                w_next      = (opcode == c_OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEM_WB;
                end else if (w_timeout) begin
                    w_next      = S_FAULT;
                    w_fault_set = 2'b01;
                end
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end else if (w_timeout) begin
                    w_next      = S_FAULT;
                    w_fault_set = 2'b01;
                end
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'b100000: alu_control = c_ALU_ADD;
                    6'b100010: alu_control = c_ALU_SUB;
                    6'b100100: alu_control = c_ALU_AND;
                    6'b100101: alu_control = c_ALU_OR;
                    6'b101010: alu_control = c_ALU_SLT;
                    default:   alu_control = c_ALU_AND;
                endcase
                w_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_control   = c_ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
                w_next        = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = c_ALU_ADD;
                w_next      = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_FAULT: begin
                w_next = S_FAULT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    assign instr_count = r_count;
    assign fault       = (r_state == S_FAULT);
    assign fault_code  = r_fault_code;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_multicycle_control_unit                                 |
// | Description : Scoreboard bench for multicycle_control_unit. Instructions |
// |               are expanded into expected per-cycle control words and     |
// |               per-instruction retire records; a monitor pops and checks  |
// |               them against the DUT. Honours MCU_ILLEGAL_TRAP_EN.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_multicycle_control_unit;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MADDR = 2, P_MREAD = 3, P_MWB = 4,
                   P_MWRITE = 5, P_EXEC = 6, P_ALUWB = 7, P_BRANCH = 8, P_JUMP = 9,
                   P_ADDIEX = 10, P_ADDIWB = 11, P_FAULT = 15;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic       instr_done;
        logic       fault;
        logic [1:0] fault_code;
        logic [3:0] state;
    } ctl_t;

    typedef struct {
        int lat;
        int cnt;
    } ret_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [5:0]       opcode = '0;
    logic [5:0]       funct = '0;
    logic             mem_ready = 1'b0;
    logic             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic             reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, fault;
    logic [1:0]       pc_source, alu_src_b, fault_code;
    logic [3:0]       alu_control, state;
    logic [CNT_W-1:0] instr_count;

    multicycle_control_unit #(
        .ALU_CTRL_W (4),
        .WAIT_W     (8),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .instr_done(instr_done), .instr_count(instr_count), .fault(fault),
        .fault_code(fault_code), .state(state)
    );

    always #5 clk = ~clk;

    ctl_t got_ctl;
    assign got_ctl = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
                      ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                      alu_control, instr_done, fault, fault_code, state};

    int   checks = 0;
    int   errors = 0;
    ctl_t exp_q[$];
    ret_t ret_q[$];
    bit   mon_en = 1'b0;
    int   model_cnt = 0;
    bit   cur_nop = 1'b0;
    logic [5:0] cur_fn = '0;
    logic [1:0] cur_fc = '0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [3:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0000;
        endcase
    endfunction

    // Expected control word for one cycle of a phase, straight from the
    // strobe list of each step of the instruction.
    function automatic ctl_t cyc(input int ph, input bit rdy);
        ctl_t c = '0;
        c.state = 4'(ph);
        case (ph)
            P_FETCH:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.alu_control = 4'b0010;
                            c.ir_write = rdy; c.pc_write = rdy; end
            P_DECODE: begin c.alu_src_b = 2'b11; c.alu_control = 4'b0010; c.instr_done = cur_nop; end
            P_MADDR:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_control = 4'b0010; end
            P_MREAD:  begin c.mem_read = 1; c.iord = 1; end
            P_MWB:    begin c.mem_to_reg = 1; c.reg_write = 1; c.instr_done = 1; end
            P_MWRITE: begin c.mem_write = 1; c.iord = 1; c.instr_done = rdy; end
            P_EXEC:   begin c.alu_src_a = 1; c.alu_control = funct_alu(cur_fn); end
            P_ALUWB:  begin c.reg_dst = 1; c.reg_write = 1; c.instr_done = 1; end
            P_BRANCH: begin c.alu_src_a = 1; c.alu_control = 4'b0110; c.pc_write_cond = 1;
                            c.pc_source = 2'b01; c.instr_done = 1; end
            P_JUMP:   begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1; end
            P_ADDIEX: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_control = 4'b0010; end
            P_ADDIWB: begin c.reg_write = 1; c.instr_done = 1; end
            P_FAULT:  begin c.fault = 1; c.fault_code = cur_fc; end
            default:  c = '0;
        endcase
        if (ph != P_FAULT) c.fault_code = 2'b00;
        return c;
    endfunction

    // One clock of stimulus: present mem_ready, queue the expected word.
    task automatic step(input int ph, input bit rdy);
        mem_ready = rdy;
        exp_q.push_back(cyc(ph, rdy));
        @(posedge clk);
        #1;
    endtask

    function automatic bit rnd();
        return 1'($urandom);
    endfunction

    function automatic int base_lat(input logic [5:0] op);
        case (op)
            OP_LW:            return 5;
            OP_SW, OP_R, OP_ADDI: return 4;
            OP_BEQ, OP_J:     return 3;
            default:          return 2;
        endcase
    endfunction

    // Retire-level model: latency = base + waits, counter wraps at 2^CNT_W.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int wf, input int wm);
        ret_t r;
        bit   memop = (op == OP_LW) || (op == OP_SW);
        r.lat = base_lat(op) + wf + (memop ? wm : 0);
        r.cnt = model_cnt;
        ret_q.push_back(r);
        model_cnt = (model_cnt + 1) % (1 << CNT_W);
        opcode  = op;
        funct   = fn;
        cur_fn  = fn;
        cur_nop = (base_lat(op) == 2);
        repeat (wf) step(P_FETCH, 1'b0);
        step(P_FETCH, 1'b1);
        step(P_DECODE, rnd());
        case (op)
            OP_LW:   begin step(P_MADDR, rnd()); repeat (wm) step(P_MREAD, 1'b0);
                           step(P_MREAD, 1'b1); step(P_MWB, rnd()); end
            OP_SW:   begin step(P_MADDR, rnd()); repeat (wm) step(P_MWRITE, 1'b0);
                           step(P_MWRITE, 1'b1); end
            OP_R:    begin step(P_EXEC, rnd()); step(P_ALUWB, rnd()); end
            OP_BEQ:  step(P_BRANCH, rnd());
            OP_J:    step(P_JUMP, rnd());
            OP_ADDI: begin step(P_ADDIEX, rnd()); step(P_ADDIWB, rnd()); end
            default: ;
        endcase
        cur_nop = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        mon_en    = 1'b0;
        rst       = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        ret_q.delete();
        model_cnt = 0;
        cur_fc    = 2'b00;
        chk({nm, "_state"}, state, 0);
        chk({nm, "_count"}, instr_count, 0);
        chk({nm, "_fault"}, {fault, fault_code}, 0);
        chk({nm, "_wr_strobes"}, {pc_write, pc_write_cond, ir_write, reg_write,
                                  mem_write, instr_done}, 0);
        mon_en = 1'b1;
    endtask

    initial begin : monitor
        int   lat;
        ctl_t e;
        ret_t r;
        lat = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                lat = 0;
            end else begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("ctl_state%0d", e.state), got_ctl, e);
                end
                lat++;
                if (instr_done) begin
                    if (ret_q.size() == 0) begin
                        chk("unexpected_instr_done", 1, 0);
                    end else begin
                        r = ret_q.pop_front();
                        chk("retire_latency", lat, r.lat);
                        chk("count_at_retire", instr_count, r.cnt);
                    end
                    lat = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [5:0] ops[6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
        logic [5:0] fns[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                               6'b101010, 6'b111111};
        logic [5:0] op;

        do_reset("rst_init");

        // Zero-wait sequence, then a counter check.
        run_instr(OP_R, 6'b100000, 0, 0);
        run_instr(OP_LW, 6'b0, 0, 0);
        run_instr(OP_SW, 6'b0, 0, 0);
        run_instr(OP_BEQ, 6'b0, 0, 0);
        run_instr(OP_J, 6'b0, 0, 0);
        run_instr(OP_ADDI, 6'b0, 0, 0);
        chk("count_after_seq", instr_count, 6);

        // Waits up to the boundary: ready on the cycle the counter would time out.
        run_instr(OP_LW, 6'b0, 3, 3);
        run_instr(OP_SW, 6'b0, 3, 2);

        // Reset in the middle of a MEM_READ wait.
        opcode = OP_LW;
        step(P_FETCH, 1'b1);
        step(P_DECODE, 1'b0);
        step(P_MADDR, 1'b0);
        step(P_MREAD, 1'b0);
        step(P_MREAD, 1'b0);
        do_reset("rst_mid_wait");

        // Counter wrap.
        repeat (17) run_instr(OP_J, 6'b0, 0, 0);
        chk("count_wrap", instr_count, 1);

        // Fetch timeout: four stalled cycles, then FAULT holds until reset.
        do_reset("rst_pre_timeout");
        opcode = 6'($urandom);
        repeat (MEM_TIMEOUT) step(P_FETCH, 1'b0);
        cur_fc = 2'b01;
        step(P_FAULT, 1'b1);
        repeat (3) step(P_FAULT, rnd());
        do_reset("rst_after_timeout");

        // Illegal opcode.
`ifdef MCU_ILLEGAL_TRAP_EN
        opcode = 6'b111111;
        step(P_FETCH, 1'b1);
        step(P_DECODE, 1'b0);
        cur_fc = 2'b10;
        repeat (3) step(P_FAULT, rnd());
        do_reset("rst_after_trap");
`else
        run_instr(6'b111111, 6'b0, 0, 0);
        run_instr(6'b111111, 6'b0, 1, 0);
`endif

        // Randomised instruction mix with random wait states below timeout.
        repeat (120) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else op = ops[$urandom_range(0, 5)];
`ifdef MCU_ILLEGAL_TRAP_EN
            if (base_lat(op) == 2) op = OP_J;
`endif
            run_instr(op, fns[$urandom_range(0, 5)], $urandom_range(0, MEM_TIMEOUT - 1),
                      $urandom_range(0, MEM_TIMEOUT - 1));
        end

        @(negedge clk);
        #1;
        chk("final_count", instr_count, model_cnt);
        chk("exp_queue_drained", exp_q.size(), 0);
        chk("retire_queue_drained", ret_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
